// File: rtl/pc_npc_unit_if.sv
// Purpose : PC/NPC sequencer bus. Carries the control inputs (load enable,
//           next-PC select, CTI target, annul request) and the registered
//           fetch-address and status outputs.
// Latency : none; this is wiring only.
// Backpr. : le=0 is the pipeline stall and holds all sequencer state
//           except for traps.
// Ports   : master = fetch/control side, which drives the controls.
//           slave  = pc_npc_unit, which drives the pc/npc/status outputs.
interface pc_npc_unit_if;
    logic        le;          // load enable, 0 = stall
    logic [1:0]  sel;         // 00 seq, 01 branch, 10 jmpl/call, 11 trap
    logic [31:0] target;      // CTI / trap target address
    logic        annul_req;   // annul bit of the current CTI
    logic [31:0] pc;          // address of instruction being fetched
    logic [31:0] npc;         // address of next instruction
    logic        annul_o;     // instruction at pc is squashed
    logic        misalign_o;  // one-cycle pulse: misaligned CTI target
    logic        in_dslot;    // pc holds a delay-slot instruction
    logic [31:0] retire_cnt;  // retired instruction count

    modport master (
        output le, sel, target, annul_req,
        input  pc, npc, annul_o, misalign_o, in_dslot, retire_cnt
    );

    modport slave (
        input  le, sel, target, annul_req,
        output pc, npc, annul_o, misalign_o, in_dslot, retire_cnt
    );
endinterface

// File: rtl/pc_npc_unit.sv
// Purpose : SPARC-style PC/NPC sequencer with delay-slot tracking, annul,
//           misaligned-target flag and an optional retired-instruction counter.
// Latency : every output is registered and updates one cycle after the
//           qualifying edge. There is no combinational input-to-output path.
// Backpr. : le=0 stalls the unit (pc/npc/annul/state/count hold, and
//           misalign_o clears). A trap (sel=11) is taken regardless of le.
// Ports   : clk, reset (synchronous, active-high); bus (pc_npc_unit_if.slave).
// Config  : `define PC_RETIRE_CNT_EN builds the retire counter. Without it,
//           retire_cnt is tied to zero.
module pc_npc_unit (
    input  logic         clk,
    input  logic         reset,
    pc_npc_unit_if.slave bus
);

    localparam logic [1:0]  SEL_SEQ   = 2'b00;
    localparam logic [1:0]  SEL_TRAP  = 2'b11;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] RESET_NPC = 32'h0000_0004;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DSLOT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic        r_annul;
    logic        r_misalign;

    logic        w_trap;
    logic        w_cti;
    logic        w_seq;
    logic [31:0] w_tgt_aligned;
    logic        w_tgt_misaligned;

    // Input decode. A trap needs no le qualification. Branches, jmpl/call
    // and sequential advance are only accepted when the pipeline loads.
    assign w_trap           = (bus.sel == SEL_TRAP);
    assign w_cti            = bus.le && !w_trap && (bus.sel != SEL_SEQ);
    assign w_seq            = bus.le && (bus.sel == SEL_SEQ);
    assign w_tgt_aligned    = {bus.target[31:2], 2'b00};
    assign w_tgt_misaligned = (bus.target[1:0] != 2'b00);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // A CTI taken while already in DSLOT (DCTI couple) stays in DSLOT,
    // so the CTI case covers both states.
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_trap) begin
            w_state_nxt = ST_RUN;
        end else if (w_cti) begin
            w_state_nxt = ST_DSLOT;
        end else if (w_seq) begin
            w_state_nxt = ST_RUN;
        end
    end

    // ---------------------------------------------------------------
    // FSM: output logic
    // ---------------------------------------------------------------
    always_comb begin
        bus.in_dslot = 1'b0;
        if (r_state == ST_DSLOT) begin
            bus.in_dslot = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // PC / NPC / annul / misalign datapath
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_npc      <= RESET_NPC;
            r_annul    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_trap) begin
            // The trap target is used as the new pc directly, so trap
            // entry has no delay slot.
            r_pc       <= w_tgt_aligned;
            r_npc      <= w_tgt_aligned + 32'd4;
            r_annul    <= 1'b0;
            r_misalign <= 1'b0;
        end else if (w_cti) begin
            r_pc       <= r_npc;
            r_npc      <= w_tgt_aligned;
            r_annul    <= bus.annul_req;
            r_misalign <= w_tgt_misaligned;
        end else if (w_seq) begin
            // The addition wraps modulo 2^32, so 0xFFFF_FFFC advances to 0.
            r_pc       <= r_npc;
            r_npc      <= r_npc + 32'd4;
            r_annul    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            // Stall: hold everything except the one-shot misalign pulse.
            r_misalign <= 1'b0;
        end
    end

    assign bus.pc         = r_pc;
    assign bus.npc        = r_npc;
    assign bus.annul_o    = r_annul;
    assign bus.misalign_o = r_misalign;

    // ---------------------------------------------------------------
    // Retired-instruction counter
    // The instruction at pc retires when the pipeline advances past it
    // (le=1, no trap) and it was not annulled.
    // ---------------------------------------------------------------
`ifdef PC_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;
    logic        w_retire;

    assign w_retire = bus.le && !w_trap && !r_annul;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= 32'd0;
        end else if (w_retire) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.retire_cnt = r_retire_cnt;
`else
    assign bus.retire_cnt = 32'd0;
`endif

endmodule
